piso_tx_scheduler: RTL and testbench
====================================

Name: piso_tx_scheduler

Overview:
- Two-requester scheduler and sequencer for an external N-bit parallel-in/serial-out shift register. The shift register loads on EN=1/SHIFT=0, shifts right on EN=1/SHIFT=1, and drives its LSB on SOUT.
- Arbitrates round-robin between two word sources.
- Loads the granted word, then issues exactly N-1 shift strobes so that each bit is held on SOUT for DIV clock cycles.
- Sits between the transmit-side producers and the shift register, and reports frame timing to downstream logic.

Parameters:
- N, 8, shift-register width and bits per frame; legal N >= 2.
- DIV, 4, clock cycles each bit is held on SOUT; legal DIV >= 1.

Ports:
- CLK  input  1  clock, rising edge.
- N_RESET  input  1  reset, asynchronous, active-low.
- REQ  input  2  REQ[i]=1: requester i has a word ready; held until granted.
- DATA0  input  N  word from requester 0; stable while REQ[0]=1.
- DATA1  input  N  word from requester 1; stable while REQ[1]=1.
- GNT  output  2  one-cycle pulse; DATAi is consumed at this edge.
- PISO_EN  output  1  enable to the shift register.
- PISO_SHIFT  output  1  0=load, 1=shift; meaningful only when PISO_EN=1.
- PISO_DATAW  output  N  parallel load word to the shift register.
- FRAME  output  1  high while SOUT carries valid frame bits.
- BUSY  output  1  high in any state other than IDLE.
- SRC  output  1  index of the requester owning the current frame.
- DONE  output  1  one-cycle pulse after the last bit period.

Behaviour:
- States: IDLE, BIT, DONE. Registers: state, bit counter k (0..N-1), divider d (0..DIV-1), last-granted flag LG.
- All outputs are decoded combinationally from registers, except GNT and PISO_DATAW, which also depend on REQ and DATAx while in IDLE.
- Reset (async, any time including mid-frame):
  - state=IDLE, k=0, d=0, LG=1, SRC=0.
  - Every output is 0 while N_RESET=0 and immediately after release.
  - An in-progress frame is abandoned; no DONE is produced for it.
- IDLE:
  - BUSY=0, FRAME=0.
  - If REQ != 0, select winner w:
    - only one requester active: w = that requester;
    - both active: w = !LG (round-robin; requester 0 wins first after reset).
  - In the same cycle: GNT[w]=1, PISO_EN=1, PISO_SHIFT=0, PISO_DATAW=DATAw.
  - At the edge: SRC<=w, LG<=w, k<=0, d<=0, state<=BIT.
  - With no request: PISO_EN=0, PISO_DATAW='0.
- BIT:
  - FRAME=1, BUSY=1.
  - d increments each cycle.
  - When d==DIV-1 and k<N-1: PISO_EN=1, PISO_SHIFT=1 that cycle; d<=0, k<=k+1.
  - When d==DIV-1 and k==N-1: no strobe; state<=DONE.
  - PISO_EN=0 in every other BIT cycle. PISO_DATAW='0 throughout BIT.
- DONE: DONE=1, BUSY=1, FRAME=0, PISO_EN=0 for exactly one cycle, then state<=IDLE.
- Timing:
  - Bit j of the granted word is on SOUT for the cycles (load edge + j*DIV) through (load edge + (j+1)*DIV - 1).
  - FRAME is high for exactly N*DIV cycles.
  - Exactly N-1 shift strobes per frame.
  - Frame occupancy: 1 load cycle + N*DIV BIT cycles + 1 DONE cycle.
  - Back-to-back frames have a minimum grant-to-grant spacing of N*DIV+2 cycles.
- Boundary conditions:
  - REQ changes during BIT/DONE are ignored; no GNT outside IDLE.
  - A requester withdrawing REQ before grant is legal; the arbiter simply does not select it.
  - Both requesters held continuously: grants alternate 0,1,0,1...
  - DIV=1: d is unused (always 0); a shift strobe occurs in every BIT cycle except the last.
  - At most one GNT bit is ever high in a cycle.

Test Plan:
- N=8, DIV=4, reset, then REQ=01, DATA0=8'hA5 -> GNT=01 in one cycle with PISO_EN=1, SHIFT=0, DATAW=A5; SOUT (model register) reads 1,0,1,0,0,1,0,1 LSB-first, each held 4 cycles; FRAME high 32 cycles; 7 strobes; DONE one cycle later; SRC=0.
- Both REQ=11 held, DATA0=8'h0F, DATA1=8'hF0 -> grants in order 0,1,0; grant spacing 34 cycles; SRC tracks each grant; GNT never 11.
- REQ=10 only, then REQ=11 -> first grant to 1; next grant to 0 (LG=1).
- N_RESET pulsed low at BIT k=3, d=2 -> FRAME, BUSY, PISO_EN drop asynchronously; no DONE pulse; after release with REQ=01, requester 0 is granted and a fresh full frame follows.
- DIV=1, N=4, DATA0=4'b1001 -> SOUT 1,0,0,1 on consecutive cycles; strobes in 3 consecutive cycles; FRAME 4 cycles; DONE one cycle later.
- REQ toggled during BIT and DONE -> no GNT and no PISO_EN load until the next IDLE cycle.

Source files
------------

// File: rtl/piso_tx_scheduler.sv
// rtl/piso_tx_scheduler.sv - round-robin two-source scheduler and load/shift sequencer for an external PISO register
// Grants one word per frame, then holds each bit on SOUT for DIV cycles using N-1 shift strobes.
module piso_tx_scheduler #(
  parameter int N   = 8,
  parameter int DIV = 4
) (
  input  logic         CLK,
  input  logic         N_RESET,
  input  logic [1:0]   REQ,
  input  logic [N-1:0] DATA0,
  input  logic [N-1:0] DATA1,
  output logic [1:0]   GNT,
  output logic         PISO_EN,
  output logic         PISO_SHIFT,
  output logic [N-1:0] PISO_DATAW,
  output logic         FRAME,
  output logic         BUSY,
  output logic         SRC,
  output logic         DONE
);

  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BIT  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] d_q, d_d;
  logic          lg_q, lg_d;
  logic          src_q, src_d;
  logic          run_q;
  logic          win;
  logic          idle_grant;
  logic          period_end;
  logic          strobe;

  // run_q keeps every output quiet until the first clock edge after reset release.
  always_comb begin
    win        = (REQ == 2'b11) ? ~lg_q : REQ[1];
    idle_grant = (state_q == S_IDLE) && run_q && (REQ != 2'b00);
    period_end = (d_q == D_LAST);
    strobe     = (state_q == S_BIT) && period_end && (k_q != K_LAST);

    state_d = state_q;
    k_d     = k_q;
    d_d     = d_q;
    lg_d    = lg_q;
    src_d   = src_q;
    case (state_q)
      S_IDLE: begin
        if (idle_grant) begin
          state_d = S_BIT;
          k_d     = '0;
          d_d     = '0;
          lg_d    = win;
          src_d   = win;
        end
      end
      S_BIT: begin
        if (period_end) begin
          d_d = '0;
          if (k_q == K_LAST) begin
            state_d = S_DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end else begin
          d_d = d_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge N_RESET) begin
    if (!N_RESET) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      d_q     <= '0;
      lg_q    <= 1'b1;
      src_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      d_q     <= d_d;
      lg_q    <= lg_d;
      src_q   <= src_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    GNT        = idle_grant ? (win ? 2'b10 : 2'b01) : 2'b00;
    PISO_EN    = idle_grant || strobe;
    PISO_SHIFT = strobe;
    PISO_DATAW = idle_grant ? (win ? DATA1 : DATA0) : '0;
    FRAME      = (state_q == S_BIT);
    BUSY       = (state_q != S_IDLE);
    DONE       = (state_q == S_DONE);
    SRC        = src_q;
  end

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// tb/tb_piso_tx_scheduler.sv - self-checking bench for piso_tx_scheduler (N=8/DIV=4 and N=4/DIV=1 instances)
// A frame-offset model predicts every output each cycle; directed scenarios add literal checks.
module tb_piso_tx_scheduler;

  localparam int NA = 8;
  localparam int DA = 4;
  localparam int NB = 4;
  localparam int DB = 1;

  logic       CLK = 1'b0;
  logic       N_RESET = 1'b0;
  logic [1:0] req_a = 2'b00, req_b = 2'b00;
  logic [7:0] d0a = '0, d1a = '0;
  logic [3:0] d0b = '0, d1b = '0;

  logic [1:0] gnt_a, gnt_b;
  logic       en_a, sh_a, fr_a, bs_a, src_a, dn_a;
  logic       en_b, sh_b, fr_b, bs_b, src_b, dn_b;
  logic [7:0] dw_a;
  logic [3:0] dw_b;
  logic [15:0] act_a, act_b;

  always #5 CLK = ~CLK;

  piso_tx_scheduler #(.N(NA), .DIV(DA)) u_a (
    .CLK(CLK), .N_RESET(N_RESET), .REQ(req_a), .DATA0(d0a), .DATA1(d1a),
    .GNT(gnt_a), .PISO_EN(en_a), .PISO_SHIFT(sh_a), .PISO_DATAW(dw_a),
    .FRAME(fr_a), .BUSY(bs_a), .SRC(src_a), .DONE(dn_a)
  );

  piso_tx_scheduler #(.N(NB), .DIV(DB)) u_b (
    .CLK(CLK), .N_RESET(N_RESET), .REQ(req_b), .DATA0(d0b), .DATA1(d1b),
    .GNT(gnt_b), .PISO_EN(en_b), .PISO_SHIFT(sh_b), .PISO_DATAW(dw_b),
    .FRAME(fr_b), .BUSY(bs_b), .SRC(src_b), .DONE(dn_b)
  );

  assign act_a = {gnt_a, en_a, sh_a, dw_a, fr_a, bs_a, src_a, dn_a};
  assign act_b = {gnt_b, en_b, sh_b, 4'b0000, dw_b, fr_b, bs_b, src_b, dn_b};

  // Owned by the compare process
  int         vec = 0;
  int         mis = 0;
  int         cyc = 0;
  int         lrd = 0;
  bit         m_act [2];
  int         m_o   [2];
  bit         m_src [2];
  bit         m_lg  [2];
  bit         m_run [2];
  logic [7:0] m_word[2];
  logic [7:0] sr    [2];
  logic [7:0] cap   [2];
  int         frame_cnt [2];
  int         strobe_cnt[2];
  int         done_cnt  [2];
  int         glog_w[$];
  int         glog_t[$];

  // Literal expectations posted by the stimulus, compared by the compare process
  string lq_n[$];
  int    lq_g[$];
  int    lq_e[$];

  task automatic model_cycle(input int i);
    int n, dv, o;
    bit w;
    logic [1:0]  rq, eg;
    logic [7:0]  x0, x1, edw;
    logic        een, esh, efr, ebs, esrc, edn;
    logic [15:0] a, e;
    n  = (i == 0) ? NA : NB;
    dv = (i == 0) ? DA : DB;
    rq = (i == 0) ? req_a : req_b;
    x0 = (i == 0) ? d0a : {4'b0000, d0b};
    x1 = (i == 0) ? d1a : {4'b0000, d1b};
    a  = (i == 0) ? act_a : act_b;
    o = 0; w = 1'b0;
    eg = 2'b00; een = 1'b0; esh = 1'b0; edw = '0;
    efr = 1'b0; ebs = 1'b0; esrc = 1'b0; edn = 1'b0;
    if (!N_RESET) begin
      m_act[i] = 1'b0; m_o[i] = 0; m_src[i] = 1'b0; m_lg[i] = 1'b1; m_run[i] = 1'b0;
    end else begin
      esrc = m_src[i];
      if (m_act[i]) begin
        o = m_o[i];
        ebs = 1'b1;
        if (o <= n * dv) begin
          efr = 1'b1;
          if ((o % dv) == 0 && o < n * dv) begin
            een = 1'b1; esh = 1'b1;
          end
        end else begin
          edn = 1'b1;
        end
      end else if (m_run[i] && rq != 2'b00) begin
        w = (rq == 2'b11) ? !m_lg[i] : rq[1];
        eg[w] = 1'b1;
        een = 1'b1;
        edw = w ? x1 : x0;
      end
    end
    e = {eg, een, esh, edw, efr, ebs, esrc, edn};
    vec++;
    if (a !== e) begin
      mis++;
      $display("FAIL outputs inst%0d cycle %0d: got %h expected %h", i, cyc, a, e);
    end
    if (efr) begin
      vec++;
      if (sr[i][0] !== m_word[i][(o-1)/dv]) begin
        mis++;
        $display("FAIL sout inst%0d cycle %0d: got %b expected %b", i, cyc, sr[i][0], m_word[i][(o-1)/dv]);
      end
      if (((o - 1) % dv) == 0) cap[i][(o-1)/dv] = sr[i][0];
    end
    frame_cnt[i]  += int'(a[3]);
    strobe_cnt[i] += int'(a[13] & a[12]);
    done_cnt[i]   += int'(a[0]);
    if (i == 0 && a[15:14] != 2'b00) begin
      glog_w.push_back(int'(a[15]));
      glog_t.push_back(cyc);
    end
    // External shift register sees the outputs present at the coming edge
    if (a[13]) sr[i] = a[12] ? (sr[i] >> 1) : a[11:4];
    if (N_RESET) begin
      m_run[i] = 1'b1;
      if (m_act[i]) begin
        if (m_o[i] == n * dv + 1) m_act[i] = 1'b0;
        else m_o[i] = m_o[i] + 1;
      end else if (eg != 2'b00) begin
        m_act[i] = 1'b1; m_o[i] = 1; m_src[i] = eg[1]; m_lg[i] = eg[1]; m_word[i] = edw;
      end
    end
  endtask

  always @(negedge CLK) begin
    cyc++;
    model_cycle(0);
    model_cycle(1);
    while (lrd < lq_n.size()) begin
      vec++;
      if (lq_g[lrd] != lq_e[lrd]) begin
        mis++;
        $display("FAIL %s: got %0d expected %0d", lq_n[lrd], lq_g[lrd], lq_e[lrd]);
      end
      lrd++;
    end
  end

  int b_f, b_s, b_d, b_g;

  task automatic chk(input string nm, input int got, input int exp);
    lq_n.push_back(nm);
    lq_g.push_back(got);
    lq_e.push_back(exp);
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    N_RESET = 1'b0;
    tick(3);
    N_RESET = 1'b1;
  endtask

  task automatic snap(input int i);
    b_f = frame_cnt[i];
    b_s = strobe_cnt[i];
    b_d = done_cnt[i];
    b_g = glog_w.size();
  endtask

  task automatic wait_grant(input int i);
    int t;
    t = 0;
    @(negedge CLK);
    while (((i == 0) ? gnt_a : gnt_b) == 2'b00 && t < 200) begin
      @(negedge CLK);
      t++;
    end
    chk($sformatf("grant_timeout_inst%0d", i), int'(t >= 200), 0);
  endtask

  initial begin
    #7;
    chk("reset_outputs_a", int'(act_a), 0);
    chk("reset_outputs_b", int'(act_b), 0);

    // Single requester, A5 frame
    snap(0);
    d0a = 8'hA5; req_a = 2'b01;
    tick(2);
    N_RESET = 1'b1;
    chk("quiet_after_release", int'(act_a), 0);
    wait_grant(0);
    chk("a5_gnt", int'(gnt_a), 1);
    chk("a5_load_en", int'({en_a, sh_a}), 2);
    chk("a5_dataw", int'(dw_a), 8'hA5);
    tick(1); req_a = 2'b00;
    tick(40);
    chk("a5_frame_cycles", frame_cnt[0] - b_f, 32);
    chk("a5_strobes", strobe_cnt[0] - b_s, 7);
    chk("a5_done", done_cnt[0] - b_d, 1);
    chk("a5_sout_bits", int'(cap[0]), 8'hA5);
    chk("a5_grants", glog_w.size() - b_g, 1);
    chk("a5_src", int'(src_a), 0);

    // Both held: alternation 0,1,0 with 34-cycle spacing
    do_reset;
    snap(0);
    d0a = 8'h0F; d1a = 8'hF0; req_a = 2'b11;
    repeat (3) begin
      wait_grant(0);
      tick(1);
    end
    req_a = 2'b00;
    tick(40);
    chk("rr_grants", glog_w.size() - b_g, 3);
    chk("rr_first", glog_w[b_g], 0);
    chk("rr_second", glog_w[b_g+1], 1);
    chk("rr_third", glog_w[b_g+2], 0);
    chk("rr_space1", glog_t[b_g+1] - glog_t[b_g], 34);
    chk("rr_space2", glog_t[b_g+2] - glog_t[b_g+1], 34);
    chk("rr_src_last", int'(src_a), 0);

    // Requester 1 alone, REQ toggled through BIT and DONE, then both
    do_reset;
    snap(0);
    d0a = 8'h33; d1a = 8'h5A; req_a = 2'b10;
    wait_grant(0);
    chk("r1_dataw", int'(dw_a), 8'h5A);
    tick(1); req_a = 2'b01;
    tick(10); req_a = 2'b11;
    tick(10); req_a = 2'b00;
    tick(12); req_a = 2'b10;
    chk("toggle_done_state", int'({dn_a, gnt_a}), 4);
    tick(1); req_a = 2'b11;
    wait_grant(0);
    tick(1); req_a = 2'b00;
    tick(40);
    chk("lg_grants", glog_w.size() - b_g, 2);
    chk("lg_first", glog_w[b_g], 1);
    chk("lg_second", glog_w[b_g+1], 0);
    chk("lg_space", glog_t[b_g+1] - glog_t[b_g], 34);
    chk("lg_sout_bits", int'(cap[0]), 8'h33);

    // Reset at k=3, d=2 abandons the frame
    do_reset;
    snap(0);
    d0a = 8'h3C; req_a = 2'b01;
    wait_grant(0);
    repeat (15) @(negedge CLK);
    chk("pre_reset_busy", int'({fr_a, bs_a}), 3);
    #2 N_RESET = 1'b0;
    #1 chk("async_drop", int'({fr_a, bs_a, en_a, dn_a, gnt_a}), 0);
    tick(2);
    N_RESET = 1'b1;
    chk("no_done_aborted", done_cnt[0] - b_d, 0);
    wait_grant(0);
    chk("post_reset_gnt", int'(gnt_a), 1);
    tick(1); req_a = 2'b00;
    tick(40);
    chk("abort_done_total", done_cnt[0] - b_d, 1);
    chk("abort_frame_total", frame_cnt[0] - b_f, 47);
    chk("abort_sout_bits", int'(cap[0]), 8'h3C);

    // DIV=1, N=4 instance
    do_reset;
    snap(1);
    d0b = 4'b1001; req_b = 2'b01;
    wait_grant(1);
    chk("div1_dataw", int'(dw_b), 9);
    tick(1); req_b = 2'b00;
    tick(10);
    chk("div1_frame_cycles", frame_cnt[1] - b_f, 4);
    chk("div1_strobes", strobe_cnt[1] - b_s, 3);
    chk("div1_done", done_cnt[1] - b_d, 1);
    chk("div1_sout_bits", int'(cap[1]), 9);

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
